// File: rtl/fp_res_pack_if.sv
// Beat-level bundle for the rounding/packing stage: input beat, output beat,
// and the sticky exception flag port.
interface fp_res_pack_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  logic                   in_valid;
  logic                   in_ready;
  logic                   sign;
  logic [EXP_W-1:0]       exponent;
  logic [MAN_W-1:0]       mantissa;
  logic [2:0]             grs;
  logic                   is_zero;
  logic                   is_inf;
  logic                   is_nan;
  logic                   underflow;
  logic                   overflow;
  logic [1:0]             rnd_mode;
  logic                   out_valid;
  logic                   out_ready;
  logic [EXP_W+MAN_W:0]   result;
  logic                   error;
  logic                   flag_clr;
  logic [4:0]             flags;

  modport master (
    output in_valid, sign, exponent, mantissa, grs, is_zero, is_inf, is_nan,
           underflow, overflow, rnd_mode, out_ready, flag_clr,
    input  in_ready, out_valid, result, error, flags
  );

  modport slave (
    input  in_valid, sign, exponent, mantissa, grs, is_zero, is_inf, is_nan,
           underflow, overflow, rnd_mode, out_ready, flag_clr,
    output in_ready, out_valid, result, error, flags
  );
endinterface

// File: rtl/fp_res_pack.sv
// Two-stage FP result packer: S1 applies the rounding increment, S2 resolves
// special/overflow cases and packs {sign, exponent, mantissa}.
module fp_res_pack #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic          clk,
  input logic          rst_n,
  fp_res_pack_if.slave bus
);
  localparam int               RES_W    = 1 + EXP_W + MAN_W;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [EXP_W-1:0] EXP_MAX  = {{(EXP_W-1){1'b1}}, 1'b0};
  localparam logic [1:0]       RM_RNE   = 2'b00;
  localparam logic [1:0]       RM_RTZ   = 2'b01;
  localparam logic [1:0]       RM_RUP   = 2'b10;
  localparam logic [1:0]       RM_RDN   = 2'b11;

  logic               r_s1_valid, r_s1_sign, r_s1_nan, r_s1_inf, r_s1_zero;
  logic               r_s1_unf, r_s1_ovf, r_s1_inexact;
  logic [EXP_W-1:0]   r_s1_exp;
  logic [MAN_W-1:0]   r_s1_man;
  logic [1:0]         r_s1_mode;
  logic               r_out_valid, r_error;
  logic [RES_W-1:0]   r_result;
  logic [4:0]         r_beat_fl, r_flags;

  logic               w_s2_ready, w_in_fire, w_s1_fire, w_out_fire;
  logic               w_inc, w_carry, w_special, w_round_ovf, w_inexact;
  logic [MAN_W:0]     w_man_sum;
  logic [EXP_W:0]     w_exp_sum;
  logic [RES_W-1:0]   w_ovf_res, w_res;
  logic               w_err;
  logic [4:0]         w_fl;

  // Handshake: a beat moves across a boundary on the edge where valid && ready
  // are both high; a holding stage keeps its payload until it moves on.
  assign w_s2_ready   = !r_out_valid || bus.out_ready;
  assign bus.in_ready = !r_s1_valid || w_s2_ready;
  assign w_in_fire    = bus.in_valid && bus.in_ready;
  assign w_s1_fire    = r_s1_valid && w_s2_ready;
  assign w_out_fire   = r_out_valid && bus.out_ready;

  always_comb begin
    w_inc = 1'b0;
    case (bus.rnd_mode)
      RM_RNE: w_inc = bus.grs[2] && (bus.grs[1] || bus.grs[0] || bus.mantissa[0]);
      RM_RTZ: w_inc = 1'b0;
      RM_RUP: w_inc = !bus.sign && (|bus.grs);
      RM_RDN: w_inc = bus.sign && (|bus.grs);
      default: w_inc = 1'b0;
    endcase
  end

  // On mantissa carry the low bits are already zero, so the sum slice is the
  // rounded fraction either way.
  assign w_man_sum   = {1'b0, bus.mantissa} + {{MAN_W{1'b0}}, w_inc};
  assign w_carry     = w_man_sum[MAN_W];
  assign w_exp_sum   = {1'b0, bus.exponent} + {{EXP_W{1'b0}}, w_carry};
  assign w_special   = bus.is_nan || bus.is_inf || bus.is_zero;
  assign w_round_ovf = w_carry && !w_special && (w_exp_sum >= {1'b0, EXP_ONES});
  assign w_inexact   = (|bus.grs) && !w_special && !bus.overflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid   <= 1'b0;
      r_s1_sign    <= 1'b0;
      r_s1_exp     <= '0;
      r_s1_man     <= '0;
      r_s1_nan     <= 1'b0;
      r_s1_inf     <= 1'b0;
      r_s1_zero    <= 1'b0;
      r_s1_unf     <= 1'b0;
      r_s1_ovf     <= 1'b0;
      r_s1_inexact <= 1'b0;
      r_s1_mode    <= 2'b00;
    end else begin
      if (bus.in_ready) r_s1_valid <= bus.in_valid;
      if (w_in_fire) begin
        r_s1_sign    <= bus.sign;
        r_s1_exp     <= w_exp_sum[EXP_W-1:0];
        r_s1_man     <= w_man_sum[MAN_W-1:0];
        r_s1_nan     <= bus.is_nan;
        r_s1_inf     <= bus.is_inf;
        r_s1_zero    <= bus.is_zero;
        r_s1_unf     <= bus.underflow;
        r_s1_ovf     <= bus.overflow || w_round_ovf;
        r_s1_inexact <= w_inexact;
        r_s1_mode    <= bus.rnd_mode;
      end
    end
  end

  always_comb begin
    w_ovf_res = {r_s1_sign, EXP_ONES, {MAN_W{1'b0}}};
    case (r_s1_mode)
      RM_RTZ: w_ovf_res = {r_s1_sign, EXP_MAX, {MAN_W{1'b1}}};
      RM_RUP: if (r_s1_sign)  w_ovf_res = {r_s1_sign, EXP_MAX, {MAN_W{1'b1}}};
      RM_RDN: if (!r_s1_sign) w_ovf_res = {r_s1_sign, EXP_MAX, {MAN_W{1'b1}}};
      default: ;
    endcase
    w_res = {r_s1_sign, r_s1_exp, r_s1_man};
    if (r_s1_nan)       w_res = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
    else if (r_s1_inf)  w_res = {r_s1_sign, EXP_ONES, {MAN_W{1'b0}}};
    else if (r_s1_ovf)  w_res = w_ovf_res;
    else if (r_s1_zero) w_res = {r_s1_sign, {(EXP_W+MAN_W){1'b0}}};
  end

  assign w_err = r_s1_nan || r_s1_ovf || r_s1_unf;
  assign w_fl  = {r_s1_nan, r_s1_ovf, r_s1_unf, r_s1_inexact, ~|w_res[RES_W-2:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_error     <= 1'b0;
      r_beat_fl   <= '0;
    end else begin
      if (w_s2_ready) r_out_valid <= r_s1_valid;
      if (w_s1_fire) begin
        r_result  <= w_res;
        r_error   <= w_err;
        r_beat_fl <= w_fl;
      end
    end
  end

  // A clear coinciding with a transfer keeps only the departing beat's bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_flags <= '0;
    else if (bus.flag_clr)     r_flags <= w_out_fire ? r_beat_fl : 5'b0;
    else if (w_out_fire)       r_flags <= r_flags | r_beat_fl;
  end

  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.error     = r_error;
  assign bus.flags     = r_flags;
endmodule

// File: tb/tb_fp_res_pack.sv
// Scoreboard bench for fp_res_pack: driver pushes model results per accepted
// beat, a negedge monitor pops on each output transfer and tracks sticky flags.
module tb_fp_res_pack;
  logic clk;
  logic rst_n;

  fp_res_pack_if #(.EXP_W(8), .MAN_W(23)) bus ();

  fp_res_pack #(.EXP_W(8), .MAN_W(23)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // {result[31:0], error, flags bits[4:0]}
  logic [37:0] exp_q[$];
  logic [4:0]  m_flags;
  int          total;
  int          bad;
  int          n_acc;
  int          rdy_mode;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic [37:0] model(input logic s, input logic [7:0] e,
                                        input logic [22:0] m, input logic [2:0] g,
                                        input logic [4:0] sp, input logic [1:0] md);
    logic        nan, inf, zero, unf, ovf, inc, special, rovf, ovf_any, inexact, to_inf;
    logic [23:0] mant;
    logic [8:0]  expo;
    logic [31:0] res;
    logic [4:0]  fl;
    {nan, inf, zero, unf, ovf} = sp;
    case (md)
      2'd0:    inc = g[2] && (g[1] || g[0] || m[0]);
      2'd1:    inc = 1'b0;
      2'd2:    inc = !s && (g != 3'b000);
      default: inc = s && (g != 3'b000);
    endcase
    mant    = {1'b0, m} + 24'(inc);
    expo    = {1'b0, e};
    if (mant == 24'h800000) begin
      mant = 24'h0;
      expo = expo + 9'd1;
    end
    special = nan || inf || zero;
    rovf    = !special && (m == 23'h7FFFFF) && inc && (expo >= 9'd255);
    ovf_any = ovf || rovf;
    inexact = (g != 3'b000) && !special && !ovf;
    to_inf  = (md == 2'd0) || (md == 2'd2 && !s) || (md == 2'd3 && s);
    if (nan)          res = 32'h7FC00000;
    else if (inf)     res = {s, 8'hFF, 23'h0};
    else if (ovf_any) res = to_inf ? {s, 8'hFF, 23'h0} : {s, 8'hFE, 23'h7FFFFF};
    else if (zero)    res = {s, 31'h0};
    else              res = {s, expo[7:0], mant[22:0]};
    fl = {nan, ovf_any, unf, inexact, (res[30:0] == 31'h0)};
    return {res, nan || ovf_any || unf, fl};
  endfunction

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic send(input logic s, input logic [7:0] e, input logic [22:0] m,
                      input logic [2:0] g, input logic [4:0] sp, input logic [1:0] md);
    int waits = 0;
    bus.in_valid = 1'b1;
    bus.sign     = s;
    bus.exponent = e;
    bus.mantissa = m;
    bus.grs      = g;
    {bus.is_nan, bus.is_inf, bus.is_zero, bus.underflow, bus.overflow} = sp;
    bus.rnd_mode = md;
    #1;
    while (!bus.in_ready && waits < 200) begin
      @(negedge clk);
      #1;
      waits++;
    end
    if (!bus.in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout act=in_ready_low exp=in_ready_high");
    end else begin
      exp_q.push_back(model(s, e, m, g, sp, md));
      n_acc++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      bus.in_valid = 1'b0;
      bus.sign     = 1'($urandom);
      bus.exponent = 8'($urandom);
      bus.mantissa = 23'($urandom);
      bus.grs      = 3'($urandom);
      {bus.is_nan, bus.is_inf, bus.is_zero, bus.underflow, bus.overflow} = 5'($urandom);
      bus.rnd_mode = 2'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain act=%0d_pending exp=0", exp_q.size());
    end
    @(negedge clk);
  endtask

  task automatic check_flags_now(input string name, input logic [4:0] exp);
    #3;
    chk(name, bus.flags, exp);
    @(negedge clk);
  endtask

  task automatic pulse_clr();
    bus.flag_clr = 1'b1;
    @(negedge clk);
    bus.flag_clr = 1'b0;
  endtask

  task automatic send_random();
    logic [7:0]  e;
    logic [22:0] m;
    logic [4:0]  sp;
    case ($urandom_range(0, 3))
      0:       e = 8'hFE;
      1:       e = 8'hFD;
      default: e = 8'($urandom_range(1, 254));
    endcase
    m = ($urandom_range(0, 2) == 0) ? 23'h7FFFFF : 23'($urandom);
    for (int i = 0; i < 5; i++) sp[i] = ($urandom_range(0, 9) == 0);
    bus.flag_clr = ($urandom_range(0, 15) == 0);
    send(1'($urandom), e, m, 3'($urandom_range(0, 7)), sp, 2'($urandom_range(0, 3)));
    bus.flag_clr = 1'b0;
  endtask

  // ---------------- output back-pressure ----------------
  always @(negedge clk) begin
    case (rdy_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = ($urandom_range(0, 3) != 0);
      default: bus.out_ready = 1'b0;
    endcase
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic        xfer;
    logic [37:0] e;
    logic [4:0]  bits;
    #2;
    if (rst_n) begin
      chk("flags", bus.flags, m_flags);
      xfer = bus.out_valid && bus.out_ready;
      bits = 5'b0;
      if (xfer) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output act=%h exp=none", bus.result);
        end else begin
          e = exp_q.pop_front();
          chk("result", bus.result, e[37:6]);
          chk("error", bus.error, e[5]);
          bits = e[4:0];
        end
      end
      if (bus.flag_clr)  m_flags = xfer ? bits : 5'b0;
      else if (xfer)     m_flags = m_flags | bits;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    total = 0; bad = 0; n_acc = 0; rdy_mode = 0; m_flags = 5'b0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.flag_clr = 1'b0; bus.out_ready = 1'b1;
    bus.sign = 1'b0; bus.exponent = '0; bus.mantissa = '0; bus.grs = '0;
    bus.is_nan = 1'b0; bus.is_inf = 1'b0; bus.is_zero = 1'b0;
    bus.underflow = 1'b0; bus.overflow = 1'b0; bus.rnd_mode = 2'b00;
    #1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_flags", bus.flags, 5'b0);
    chk("rst_result", bus.result, 32'h0);
    @(negedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);

    // 1.0 passes through unchanged with two-cycle latency
    send(1'b0, 8'h7F, 23'h0, 3'b000, 5'b0, 2'd0);
    #1 chk("lat_one_cycle", bus.out_valid, 1'b0);
    @(negedge clk);
    #1 chk("lat_two_cycle", bus.out_valid, 1'b1);
    drain();
    check_flags_now("flags_exact", 5'b00000);

    // mantissa carry into exponent vs truncation
    send(1'b0, 8'h7F, 23'h7FFFFF, 3'b100, 5'b0, 2'd0);
    send(1'b0, 8'h7F, 23'h7FFFFF, 3'b100, 5'b0, 2'd1);
    drain();
    check_flags_now("flags_inexact", 5'b00010);
    pulse_clr();

    // rounding overflow and mode-dependent saturation
    send(1'b0, 8'hFE, 23'h7FFFFF, 3'b110, 5'b0, 2'd0);
    drain();
    check_flags_now("flags_round_ovf", 5'b01010);
    send(1'b0, 8'hFE, 23'h7FFFFF, 3'b110, 5'b0, 2'd1);
    send(1'b1, 8'hFE, 23'h7FFFFF, 3'b110, 5'b0, 2'd2);
    send(1'b1, 8'h10, 23'h1234, 3'b001, 5'b00001, 2'd3);
    send(1'b1, 8'h10, 23'h1234, 3'b001, 5'b00001, 2'd2);
    send(1'b1, 8'h22, 23'h55, 3'b000, 5'b00100, 2'd0);
    drain();
    pulse_clr();

    // NaN outranks Inf; then clear the sticky flags
    send(1'b1, 8'h80, 23'h1, 3'b000, 5'b11000, 2'd0);
    drain();
    check_flags_now("flags_invalid", 5'b10000);
    pulse_clr();
    #1 chk("flags_after_clr", bus.flags, 5'b0);
    @(negedge clk);

    // output stall: only two beats fit, then all four emerge in order
    rdy_mode = 2;
    @(negedge clk);
    n_acc = 0;
    fork
      begin
        for (int i = 0; i < 4; i++)
          send(1'b0, 8'h40 + 8'(i), 23'(i * 3 + 1), 3'(i), 5'b0, 2'(i));
      end
      begin
        repeat (4) @(negedge clk);
        #1;
        chk("stall_accepted", 32'(n_acc), 32'd2);
        chk("stall_in_ready", bus.in_ready, 1'b0);
        rdy_mode = 0;
      end
    join
    drain();
    chk("stall_all_out", 32'(exp_q.size()), 32'd0);

    // randomized traffic with back-pressure and occasional clears
    rdy_mode = 1;
    for (int i = 0; i < 300; i++) begin
      send_random();
      if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
    end
    rdy_mode = 0;
    drain();

    // mid-cycle reset with two beats held in the pipe
    rdy_mode = 2;
    @(negedge clk);
    send(1'b0, 8'h33, 23'h1, 3'b111, 5'b00010, 2'd0);
    send(1'b1, 8'h44, 23'h2, 3'b101, 5'b0, 2'd0);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 1'b0);
    chk("mid_rst_error", bus.error, 1'b0);
    chk("mid_rst_flags", bus.flags, 5'b0);
    chk("mid_rst_result", bus.result, 32'h0);
    chk("mid_rst_in_ready", bus.in_ready, 1'b1);
    exp_q.delete();
    m_flags = 5'b0;
    rdy_mode = 0;
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    repeat (4) begin
      #1 chk("no_stale_beat", bus.out_valid, 1'b0);
      @(negedge clk);
    end
    send(1'b0, 8'h7F, 23'h0, 3'b000, 5'b0, 2'd0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
